// File: rtl/fir_ch_scheduler.sv
// fir_ch_scheduler: round-robin arbiter sharing one serial FIR MAC engine
// between NUM_CH sample producers. One sample is in flight at a time; the
// engine's result is returned tagged with the channel that produced it.
//
// Optional feature macro: FIR_SCHED_TIMEOUT_EN
//   defined   -> WAIT is bounded by a TIMEOUT-cycle watchdog; an expiry
//                raises a sticky timeout_err and drops the sample.
//   undefined -> WAIT waits indefinitely and timeout_err is tied low.
module fir_ch_scheduler #(
  parameter int NUM_CH    = 2,
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 8,
  parameter int TIMEOUT   = 64,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]       req_ready,
  output logic                    eng_valid_in,
  output logic [WIDTH-1:0]        eng_data_in,
  output logic [CH_W-1:0]         eng_ch_sel,
  input  logic                    eng_valid_out,
  input  logic [OUT_WIDTH-1:0]    eng_data_out,
  output logic                    res_valid,
  output logic [CH_W-1:0]         res_ch,
  output logic [OUT_WIDTH-1:0]    res_data,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  state_t          state;
  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] cand;
  logic            grant_found;
  logic            wd_expire;

  // Winner search: first pending channel strictly after the last grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Accept is only offered from IDLE; rst masks it so nothing is consumed during reset.
  assign req_ready = (state == IDLE && grant_found && !rst) ?
                     (NUM_CH'(1) << grant_idx) : '0;

  assign busy = (state != IDLE);

  // Main FSM: capture on accept, strobe the engine once, wait, present the result once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= CH_W'(NUM_CH - 1);
      eng_valid_in <= 1'b0;
      eng_data_in  <= '0;
      eng_ch_sel   <= '0;
      res_valid    <= 1'b0;
      res_ch       <= '0;
      res_data     <= '0;
    end else begin
      eng_valid_in <= 1'b0;
      res_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            eng_data_in  <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
            eng_ch_sel   <= grant_idx;
            last_grant   <= grant_idx;
            eng_valid_in <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // A result arriving on the expiry cycle takes priority over the abort.
          if (eng_valid_out) begin
            res_data  <= eng_data_out;
            res_ch    <= eng_ch_sel;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else if (wd_expire) begin
            state <= IDLE;
          end
        end
        RESULT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_err_reg;

  assign wd_expire   = (state == WAIT) && !eng_valid_out &&
                       (wd_cnt == WD_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_reg;

  // Watchdog: counts WAIT cycles from zero, latches a sticky error on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt          <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wd_cnt <= '0;
      end else if (state == WAIT && !wd_expire) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_expire) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
